// File: rtl/spike_aer_encoder_pkg.sv
// Shared definitions for the spike tile output path: encoder state encoding,
// index-width helpers and a lowest-set-bit isolation function.
package spike_aer_encoder_pkg;

  typedef enum logic {
    st_idle = 1'b0,
    st_emit = 1'b1
  } aer_state_e;

  // Neurons per tile in the reference configuration and its index width.
  localparam int unsigned DEFAULT_SIZE_TILE = 4;
  localparam int unsigned DEFAULT_IDX_W     = (DEFAULT_SIZE_TILE > 1) ? $clog2(DEFAULT_SIZE_TILE) : 1;

  // Widest spike vector the helper function handles.
  localparam int unsigned MAX_TILE = 64;

  // Isolates the lowest set bit of a vector as a one-hot word (zero in, zero out).
  function automatic logic [MAX_TILE-1:0] lowest_onehot(input logic [MAX_TILE-1:0] v);
    return v & (~v + MAX_TILE'(1));
  endfunction

endpackage

// File: rtl/spike_priority_encoder.sv
// Combinational lowest-index priority encoder over a spike vector.
module spike_priority_encoder #(
  parameter int unsigned size_tile = 4,
  parameter int unsigned IDX_W     = (size_tile > 1) ? $clog2(size_tile) : 1
) (
  input  logic [size_tile-1:0] vec_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 none_o,
  output logic                 single_o
);

  // Scan from the top down so the lowest set bit is the one that sticks.
  always_comb begin
    idx_o = '0;
    for (int i = int'(size_tile) - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign none_o   = ~|vec_i;
  assign single_o = (|vec_i) && ((vec_i & (vec_i - size_tile'(1))) == '0);

endmodule

// File: rtl/spike_aer_encoder.sv
// Buffers spike vectors from a neuron tile and serialises them into
// address-event words, lowest neuron first, vectors in arrival order.
module spike_aer_encoder
  import spike_aer_encoder_pkg::*;
#(
  parameter int unsigned size_tile   = 4,
  parameter int unsigned size_addr   = 16,
  parameter int unsigned tile_base   = 0,
  parameter int unsigned num_buffers = 2,
  parameter int unsigned size_drop   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_spikeValid,
  input  logic [size_tile-1:0] in_spike,
  output logic                 out_aerValid,
  input  logic                 in_aerReady,
  output logic [size_addr-1:0] out_aerAddr,
  output logic                 out_aerLast,
  output logic [size_drop-1:0] out_dropCount
);

  localparam int unsigned IDX_W = (size_tile > 1) ? $clog2(size_tile) : 1;
  localparam int unsigned PTR_W = (num_buffers > 1) ? $clog2(num_buffers) : 1;
  localparam int unsigned CNT_W = $clog2(num_buffers + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(num_buffers - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  logic [size_tile-1:0] mem_q [num_buffers];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [size_tile-1:0] pending_q, pending_d;
  logic [size_drop-1:0] drop_q, drop_d;
  aer_state_e           state_q, state_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_none, enc_single;
  logic             emit, xfer, pop, push_req, push, drop;

  spike_priority_encoder #(
    .size_tile (size_tile),
    .IDX_W     (IDX_W)
  ) u_enc (
    .vec_i    (pending_q),
    .idx_o    (enc_idx),
    .none_o   (enc_none),
    .single_o (enc_single)
  );

  assign emit     = (state_q == st_emit);
  assign xfer     = emit && in_aerReady;
  assign pop      = xfer && enc_single;
  assign push_req = in_spikeValid && (|in_spike);
  // A full FIFO still takes the vector when the head leaves in the same cycle.
  assign push     = push_req && ((count_q < CNT_W'(num_buffers)) || pop);
  assign drop     = push_req && !push;

  assign out_aerValid  = emit && !enc_none;
  assign out_aerAddr   = emit ? (size_addr'(tile_base) + size_addr'(enc_idx)) : '0;
  assign out_aerLast   = emit && enc_single;
  assign out_dropCount = drop_q;

  // Next-state for the FSM, FIFO pointers, working mask and drop counter.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    drop_d    = drop_q;

    if (push) tail_d = ptr_inc(tail_q);
    if (drop && (drop_q != '1)) drop_d = drop_q + size_drop'(1);

    unique case (state_q)
      st_idle: begin
        if (count_q != '0) begin
          state_d   = st_emit;
          pending_d = mem_q[head_q];
        end
      end
      st_emit: begin
        if (xfer) begin
          pending_d = size_tile'(MAX_TILE'(pending_q) & ~lowest_onehot(MAX_TILE'(pending_q)));
          if (enc_single) begin
            head_d = ptr_inc(head_q);
            // Follow-on head: an older buffered entry, else the vector arriving now.
            if (count_q > CNT_W'(1)) begin
              pending_d = mem_q[ptr_inc(head_q)];
            end else if (push) begin
              pending_d = in_spike;
            end else begin
              state_d = st_idle;
            end
          end
        end
      end
      default: state_d = st_idle;
    endcase
  end

  // Control state: FSM, pointers, occupancy and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= st_idle;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Data storage: FIFO entries and the working mask carry no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= in_spike;
    pending_q <= pending_d;
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder with tile_base=0x100, four neurons, two buffers.
module tb_spike_aer_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_spikeValid;
  logic [3:0]  in_spike;
  logic        out_aerValid;
  logic        in_aerReady;
  logic [15:0] out_aerAddr;
  logic        out_aerLast;
  logic [7:0]  out_dropCount;

  int n_vec = 0;
  int n_bad = 0;

  spike_aer_encoder #(
    .size_tile   (4),
    .size_addr   (16),
    .tile_base   (32'h100),
    .num_buffers (2),
    .size_drop   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_spikeValid (in_spikeValid),
    .in_spike      (in_spike),
    .out_aerValid  (out_aerValid),
    .in_aerReady   (in_aerReady),
    .out_aerAddr   (out_aerAddr),
    .out_aerLast   (out_aerLast),
    .out_dropCount (out_dropCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] v);
    in_spikeValid = 1'b1;
    in_spike      = v;
    step();
    in_spikeValid = 1'b0;
    in_spike      = '0;
  endtask

  // Check the word on the bus now, then advance one clock.
  task automatic expect_word(input string tag, input logic [15:0] addr, input logic last);
    check({tag, ".valid"}, 32'(out_aerValid), 32'd1);
    check({tag, ".addr"},  32'(out_aerAddr),  32'(addr));
    check({tag, ".last"},  32'(out_aerLast),  32'(last));
    step();
  endtask

  initial begin
    reset = 1'b1; in_spikeValid = 1'b0; in_spike = '0; in_aerReady = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst.valid", 32'(out_aerValid), 32'd0);
    check("rst.addr",  32'(out_aerAddr),  32'd0);
    check("rst.last",  32'(out_aerLast),  32'd0);
    check("rst.drop",  32'(out_dropCount), 32'd0);

    // Basic emission of 4'b1010.
    in_aerReady = 1'b1;
    push_one(4'b1010);
    check("basic.lat", 32'(out_aerValid), 32'd0);
    step();
    expect_word("basic.w0", 16'h101, 1'b0);
    expect_word("basic.w1", 16'h103, 1'b1);
    check("basic.idle", 32'(out_aerValid), 32'd0);

    // Backpressure on 4'b0111.
    in_aerReady = 1'b0;
    push_one(4'b0111);
    step();
    expect_word("bp.hold0", 16'h100, 1'b0);
    expect_word("bp.hold1", 16'h100, 1'b0);
    expect_word("bp.hold2", 16'h100, 1'b0);
    in_aerReady = 1'b1;
    expect_word("bp.w0", 16'h100, 1'b0);
    expect_word("bp.w1", 16'h101, 1'b0);
    expect_word("bp.w2", 16'h102, 1'b1);
    check("bp.idle", 32'(out_aerValid), 32'd0);

    // Overflow: third full vector is dropped.
    in_aerReady = 1'b0;
    push_one(4'b1111);
    push_one(4'b1111);
    push_one(4'b1111);
    check("ovf.drop", 32'(out_dropCount), 32'd1);
    in_aerReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      expect_word("ovf.a", 16'h100, 1'b0);
      expect_word("ovf.b", 16'h101, 1'b0);
      expect_word("ovf.c", 16'h102, 1'b0);
      expect_word("ovf.d", 16'h103, 1'b1);
    end
    check("ovf.idle", 32'(out_aerValid), 32'd0);
    check("ovf.drop2", 32'(out_dropCount), 32'd1);

    // Full FIFO, push coinciding with the head's last word.
    in_aerReady = 1'b0;
    push_one(4'b0011);
    push_one(4'b0100);
    expect_word("full.hold", 16'h100, 1'b0);
    in_aerReady = 1'b1;
    expect_word("full.a0", 16'h100, 1'b0);
    in_spikeValid = 1'b1;
    in_spike      = 4'b1000;
    expect_word("full.a1", 16'h101, 1'b1);
    in_spikeValid = 1'b0;
    in_spike      = '0;
    check("full.drop", 32'(out_dropCount), 32'd1);
    expect_word("full.b", 16'h102, 1'b1);
    expect_word("full.c", 16'h103, 1'b1);
    check("full.idle", 32'(out_aerValid), 32'd0);

    // Zero vector is ignored.
    push_one(4'b0000);
    check("zero.valid0", 32'(out_aerValid), 32'd0);
    step();
    check("zero.valid1", 32'(out_aerValid), 32'd0);
    check("zero.drop", 32'(out_dropCount), 32'd1);

    // Reset while 4'b1111 is half emitted.
    push_one(4'b1111);
    step();
    expect_word("mrst.w0", 16'h100, 1'b0);
    expect_word("mrst.w1", 16'h101, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst.valid", 32'(out_aerValid), 32'd0);
    check("mrst.drop", 32'(out_dropCount), 32'd0);
    step();
    check("mrst.quiet", 32'(out_aerValid), 32'd0);
    push_one(4'b0001);
    step();
    expect_word("mrst.single", 16'h100, 1'b1);
    check("mrst.idle", 32'(out_aerValid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
